// File: rtl/cfeb_resync_seq_pkg.sv
// Shared types and constants for the CFEB optical-link resync sequencer.
package cfeb_resync_seq_pkg;

  localparam int MXCFEB = 5;
  localparam int PTR_W  = 3;

  localparam logic [7:0] KCHAR_IDLE = 8'hBC;
  localparam logic [7:0] KCHAR_MARK = 8'hFC;

  typedef enum logic [2:0] {
    IDLE,
    RST,
    WAIT_LOCK,
    ALIGN,
    RETRY,
    DONE,
    FAIL
  } state_t;

  function automatic logic [MXCFEB-1:0] cfebOneHot(input logic [PTR_W-1:0] idx);
    logic [MXCFEB-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin pointer advance, wrapping after the last fibre
  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] idx);
    return (idx == PTR_W'(MXCFEB - 1)) ? '0 : idx + 1'b1;
  endfunction

  function automatic logic isKchar(input logic [7:0] k);
    return (k == KCHAR_IDLE) || (k == KCHAR_MARK);
  endfunction

endpackage

// File: rtl/cfeb_rr_pick.sv
// Combinational round-robin finder: first pending fibre at or after the pointer.
module cfeb_rr_pick
  import cfeb_resync_seq_pkg::*;
(
  input  logic [MXCFEB-1:0] i_pending,
  input  logic [PTR_W-1:0]  i_rr_ptr,
  output logic [PTR_W-1:0]  o_sel,
  output logic              o_valid
);

  localparam logic [PTR_W:0] MX_EXT = (PTR_W + 1)'(MXCFEB);

  logic [PTR_W:0] w_idx;

  // Scan from the farthest offset down so the nearest pending fibre wins last
  always_comb begin
    o_sel   = '0;
    o_valid = 1'b0;
    w_idx   = '0;
    for (int k = MXCFEB - 1; k >= 0; k--) begin
      w_idx = {1'b0, i_rr_ptr} + (PTR_W + 1)'(k);
      if (w_idx >= MX_EXT) w_idx = w_idx - MX_EXT;
      if (i_pending[w_idx[PTR_W-1:0]]) begin
        o_sel   = w_idx[PTR_W-1:0];
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cfeb_resync_seq.sv
// DCFEB optical-link resync sequencer: one shared engine walks enabled fibres
// through receiver reset, lock wait and frame-marker alignment.
module cfeb_resync_seq
  import cfeb_resync_seq_pkg::*;
#(
  parameter int RST_CYCLES = 8,
  parameter int TIMEOUT    = 4095,
  parameter int GOOD_CNT   = 64,
  parameter int MAX_RETRY  = 3
) (
  input  logic              clock,
  input  logic              global_reset,
  input  logic              ttc_resync,
  input  logic              auto_resync_en,
  input  logic              cfebs_lostsync,
  input  logic [MXCFEB-1:0] cfeb_fiber_enable,
  input  logic [MXCFEB-1:0] link_good,
  input  logic [7:0]        cfeb0_kchar,
  input  logic [7:0]        cfeb1_kchar,
  input  logic [7:0]        cfeb2_kchar,
  input  logic [7:0]        cfeb3_kchar,
  input  logic [7:0]        cfeb4_kchar,
  output logic [MXCFEB-1:0] cfeb_rx_reset,
  output logic [MXCFEB-1:0] cfeb_sync_done,
  output logic [MXCFEB-1:0] cfeb_sync_fail,
  output logic              resync_busy,
  output logic [7:0]        resync_count
);

  localparam logic [15:0] RST_LAST   = 16'(RST_CYCLES - 1);
  localparam logic [15:0] TO_LAST    = 16'(TIMEOUT - 1);
  localparam logic [7:0]  GOOD_LAST  = 8'(GOOD_CNT - 1);
  localparam logic [3:0]  RETRY_LAST = 4'(MAX_RETRY - 1);

  state_t            r_state;
  logic [PTR_W-1:0]  r_sel;
  logic [PTR_W-1:0]  r_rr_ptr;
  logic [MXCFEB-1:0] r_pending;
  logic [15:0]       r_timer;
  logic [7:0]        r_good;
  logic [3:0]        r_retry;
  logic [MXCFEB-1:0] r_rx_reset;
  logic [MXCFEB-1:0] r_sync_done;
  logic [MXCFEB-1:0] r_sync_fail;
  logic              r_busy;
  logic [7:0]        r_count;
  logic              r_boot;
  logic              r_ttc_q;
  logic              r_lost_q;

  logic              w_start;
  logic [7:0]        w_kchar;
  logic [PTR_W-1:0]  w_pick_sel;
  logic              w_pick_valid;
  logic [MXCFEB-1:0] w_sel_onehot;
  logic              w_sel_enabled;
  logic              w_sel_link;
  logic              w_kvalid;
  logic              w_abort;
  logic              w_busy_nxt;

  // r_boot comes out of reset set so the first clock after release starts a resync
  always_ff @(posedge clock or posedge global_reset) begin
    if (global_reset) begin
      r_boot   <= 1'b1;
      r_ttc_q  <= 1'b0;
      r_lost_q <= 1'b0;
    end else begin
      r_boot   <= 1'b0;
      r_ttc_q  <= ttc_resync;
      r_lost_q <= cfebs_lostsync;
    end
  end

  assign w_start = r_boot
                 | (ttc_resync & ~r_ttc_q)
                 | (auto_resync_en & cfebs_lostsync & ~r_lost_q);

  always_comb begin
    case (r_sel)
      3'd0:    w_kchar = cfeb0_kchar;
      3'd1:    w_kchar = cfeb1_kchar;
      3'd2:    w_kchar = cfeb2_kchar;
      3'd3:    w_kchar = cfeb3_kchar;
      3'd4:    w_kchar = cfeb4_kchar;
      default: w_kchar = 8'h00;
    endcase
  end

  assign w_sel_onehot  = cfebOneHot(r_sel);
  assign w_sel_enabled = cfeb_fiber_enable[r_sel];
  assign w_sel_link    = link_good[r_sel];
  assign w_kvalid      = isKchar(w_kchar) & w_sel_link;
  assign w_abort       = (r_state inside {RST, WAIT_LOCK, ALIGN, RETRY}) & ~w_sel_enabled;

  // Predicts busy for the next cycle so the output stays registered yet exact
  always_comb begin
    if (w_start)
      w_busy_nxt = |cfeb_fiber_enable;
    else if (r_state == IDLE)
      w_busy_nxt = |r_pending;
    else if ((r_state == DONE) || (r_state == FAIL))
      w_busy_nxt = |(r_pending & ~w_sel_onehot);
    else
      w_busy_nxt = 1'b1;
  end

  cfeb_rr_pick u_pick (
    .i_pending (r_pending),
    .i_rr_ptr  (r_rr_ptr),
    .o_sel     (w_pick_sel),
    .o_valid   (w_pick_valid)
  );

  always_ff @(posedge clock or posedge global_reset) begin
    if (global_reset) begin
      r_state     <= IDLE;
      r_sel       <= '0;
      r_rr_ptr    <= '0;
      r_pending   <= '0;
      r_timer     <= '0;
      r_good      <= '0;
      r_retry     <= '0;
      r_rx_reset  <= '0;
      r_sync_done <= '0;
      r_sync_fail <= '0;
      r_busy      <= 1'b0;
      r_count     <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_start) begin
        // A new request always wins, even over a sequence in flight
        r_state     <= IDLE;
        r_pending   <= cfeb_fiber_enable;
        r_sync_done <= ~cfeb_fiber_enable;
        r_sync_fail <= '0;
        r_rx_reset  <= '0;
        r_timer     <= '0;
        r_good      <= '0;
        r_retry     <= '0;
        if (r_count != 8'hFF) r_count <= r_count + 8'd1;
      end else if (w_abort) begin
        r_rx_reset <= '0;
        r_timer    <= '0;
        r_state    <= DONE;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_pick_valid) begin
              r_sel      <= w_pick_sel;
              r_retry    <= '0;
              r_timer    <= '0;
              r_rx_reset <= cfebOneHot(w_pick_sel);
              r_state    <= RST;
            end
          end
          RST: begin
            if (r_timer == RST_LAST) begin
              r_rx_reset <= '0;
              r_timer    <= '0;
              r_state    <= WAIT_LOCK;
            end else begin
              r_timer <= r_timer + 16'd1;
            end
          end
          WAIT_LOCK: begin
            if (w_sel_link) begin
              r_timer <= '0;
              r_good  <= '0;
              r_state <= ALIGN;
            end else if (r_timer == TO_LAST) begin
              r_timer <= '0;
              r_state <= RETRY;
            end else begin
              r_timer <= r_timer + 16'd1;
            end
          end
          ALIGN: begin
            r_good <= w_kvalid ? r_good + 8'd1 : 8'd0;
            if (w_kvalid && (r_good == GOOD_LAST)) begin
              r_timer <= '0;
              r_state <= DONE;
            end else if (r_timer == TO_LAST) begin
              r_timer <= '0;
              r_state <= RETRY;
            end else begin
              r_timer <= r_timer + 16'd1;
            end
          end
          RETRY: begin
            r_retry <= r_retry + 4'd1;
            r_timer <= '0;
            if (r_retry == RETRY_LAST) begin
              r_state <= FAIL;
            end else begin
              r_rx_reset <= w_sel_onehot;
              r_state    <= RST;
            end
          end
          DONE: begin
            r_sync_done <= r_sync_done | w_sel_onehot;
            r_pending   <= r_pending & ~w_sel_onehot;
            r_rr_ptr    <= nextPtr(r_sel);
            r_timer     <= '0;
            r_state     <= IDLE;
          end
          FAIL: begin
            r_sync_done <= r_sync_done | w_sel_onehot;
            r_sync_fail <= r_sync_fail | w_sel_onehot;
            r_pending   <= r_pending & ~w_sel_onehot;
            r_rr_ptr    <= nextPtr(r_sel);
            r_timer     <= '0;
            r_state     <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign cfeb_rx_reset  = r_rx_reset;
  assign cfeb_sync_done = r_sync_done;
  assign cfeb_sync_fail = r_sync_fail;
  assign resync_busy    = r_busy;
  assign resync_count   = r_count;

endmodule

// File: tb/tb_cfeb_resync_seq.sv
// Scoreboard bench for cfeb_resync_seq: expected done/fail events and rx_reset
// pulses are queued by the stimulus and consumed by a negedge monitor.
module tb_cfeb_resync_seq;

  localparam int RST_CYCLES = 8;
  localparam int TIMEOUT    = 160;
  localparam int GOOD_CNT   = 64;
  localparam int MAX_RETRY  = 3;

  logic       clock = 1'b0;
  logic       global_reset;
  logic       ttc_resync;
  logic       auto_resync_en;
  logic       cfebs_lostsync;
  logic [4:0] cfeb_fiber_enable;
  logic [4:0] link_good;
  logic [7:0] kchar [5];
  logic [4:0] cfeb_rx_reset;
  logic [4:0] cfeb_sync_done;
  logic [4:0] cfeb_sync_fail;
  logic       resync_busy;
  logic [7:0] resync_count;

  typedef struct {
    logic [4:0] done;
    logic [4:0] fail;
    logic [7:0] count;
  } doneExp_t;

  typedef struct {
    int fibre;
    int width;
  } pulseExp_t;

  doneExp_t  doneQ[$];
  pulseExp_t pulseQ[$];
  doneExp_t  monDone;
  pulseExp_t monPulse;
  logic [4:0] prevDone;
  logic [4:0] prevFail;
  int hiCnt [5];
  int nVectors = 0;
  int nMiscompares = 0;
  int lat;

  always #5 clock = ~clock;

  cfeb_resync_seq #(
    .RST_CYCLES (RST_CYCLES),
    .TIMEOUT    (TIMEOUT),
    .GOOD_CNT   (GOOD_CNT),
    .MAX_RETRY  (MAX_RETRY)
  ) dut (
    .clock             (clock),
    .global_reset      (global_reset),
    .ttc_resync        (ttc_resync),
    .auto_resync_en    (auto_resync_en),
    .cfebs_lostsync    (cfebs_lostsync),
    .cfeb_fiber_enable (cfeb_fiber_enable),
    .link_good         (link_good),
    .cfeb0_kchar       (kchar[0]),
    .cfeb1_kchar       (kchar[1]),
    .cfeb2_kchar       (kchar[2]),
    .cfeb3_kchar       (kchar[3]),
    .cfeb4_kchar       (kchar[4]),
    .cfeb_rx_reset     (cfeb_rx_reset),
    .cfeb_sync_done    (cfeb_sync_done),
    .cfeb_sync_fail    (cfeb_sync_fail),
    .resync_busy       (resync_busy),
    .resync_count      (resync_count)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic reportUnexpected(input string name, input logic [31:0] actual);
    nVectors++;
    nMiscompares++;
    $display("[TB] FAIL %s: got 0x%0h, expected no event", name, actual);
  endtask

  task automatic expectDone(input logic [4:0] d, input logic [4:0] f, input logic [7:0] c);
    doneExp_t e;
    e.done  = d;
    e.fail  = f;
    e.count = c;
    doneQ.push_back(e);
  endtask

  task automatic expectPulse(input int fibre, input int width);
    pulseExp_t p;
    p.fibre = fibre;
    p.width = width;
    pulseQ.push_back(p);
  endtask

  task automatic applyStimulus(input logic [4:0] en, input logic [4:0] lg);
    cfeb_fiber_enable = en;
    link_good         = lg;
  endtask

  task automatic pulseTtc();
    ttc_resync = 1'b1;
    @(negedge clock);
    ttc_resync = 1'b0;
  endtask

  task automatic waitDone(input logic [4:0] target, input int budget, input string name);
    int n = 0;
    while (cfeb_sync_done !== target && n < budget) begin
      @(negedge clock);
      n++;
    end
    checkOutput(name, 32'(cfeb_sync_done), 32'(target));
  endtask

  // Monitor: pops an expectation whenever done/fail change or an rx_reset pulse ends
  always @(negedge clock) begin
    if (global_reset) begin
      prevDone = cfeb_sync_done;
      prevFail = cfeb_sync_fail;
      for (int i = 0; i < 5; i++) hiCnt[i] = 0;
    end else begin
      if (cfeb_sync_done !== prevDone || cfeb_sync_fail !== prevFail) begin
        if (doneQ.size() == 0) begin
          reportUnexpected("done/fail event", {22'd0, cfeb_sync_done, cfeb_sync_fail});
        end else begin
          monDone = doneQ.pop_front();
          checkOutput("sync_done", 32'(cfeb_sync_done), 32'(monDone.done));
          checkOutput("sync_fail", 32'(cfeb_sync_fail), 32'(monDone.fail));
          checkOutput("resync_count", 32'(resync_count), 32'(monDone.count));
        end
        prevDone = cfeb_sync_done;
        prevFail = cfeb_sync_fail;
      end
      if ($countones(cfeb_rx_reset) > 1) reportUnexpected("rx_reset one-hot", 32'(cfeb_rx_reset));
      for (int i = 0; i < 5; i++) begin
        if (cfeb_rx_reset[i]) begin
          hiCnt[i]++;
        end else if (hiCnt[i] > 0) begin
          if (pulseQ.size() == 0) begin
            reportUnexpected("rx_reset pulse", 32'(i));
          end else begin
            monPulse = pulseQ.pop_front();
            checkOutput("rx_reset fibre", 32'(i), 32'(monPulse.fibre));
            checkOutput("rx_reset width", 32'(hiCnt[i]), 32'(monPulse.width));
          end
          hiCnt[i] = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    global_reset   = 1'b1;
    ttc_resync     = 1'b0;
    auto_resync_en = 1'b0;
    cfebs_lostsync = 1'b0;
    applyStimulus(5'h1F, 5'h1F);
    for (int i = 0; i < 5; i++) kchar[i] = 8'hBC;
    repeat (3) @(negedge clock);

    checkOutput("reset rx_reset", 32'(cfeb_rx_reset), 32'h0);
    checkOutput("reset sync_done", 32'(cfeb_sync_done), 32'h0);
    checkOutput("reset sync_fail", 32'(cfeb_sync_fail), 32'h0);
    checkOutput("reset busy", 32'(resync_busy), 32'h0);
    checkOutput("reset count", 32'(resync_count), 32'h0);

    // Power-up resync of all five fibres in order 0..4
    for (int i = 0; i < 5; i++) expectPulse(i, RST_CYCLES);
    expectDone(5'h01, 5'h00, 8'd1);
    expectDone(5'h03, 5'h00, 8'd1);
    expectDone(5'h07, 5'h00, 8'd1);
    expectDone(5'h0F, 5'h00, 8'd1);
    expectDone(5'h1F, 5'h00, 8'd1);
    global_reset = 1'b0;
    lat = 0;
    while (!cfeb_sync_done[0] && lat < 200) begin
      @(negedge clock);
      lat++;
    end
    checkOutput("t1 latency", 32'(lat), 32'(1 + 1 + RST_CYCLES + 1 + GOOD_CNT + 1));
    waitDone(5'h1F, 600, "t1 all done");
    checkOutput("t1 busy idle", 32'(resync_busy), 32'h0);
    checkOutput("t1 count", 32'(resync_count), 32'd1);
    repeat (5) @(negedge clock);

    // Only fibres 0 and 2 enabled
    expectDone(5'h1A, 5'h00, 8'd2);
    expectDone(5'h1B, 5'h00, 8'd2);
    expectDone(5'h1F, 5'h00, 8'd2);
    expectPulse(0, RST_CYCLES);
    expectPulse(2, RST_CYCLES);
    applyStimulus(5'h05, 5'h1F);
    pulseTtc();
    waitDone(5'h1F, 400, "t2 done");
    repeat (5) @(negedge clock);

    // Fibre 3 never locks: three reset pulses then fail; arbitration starts at fibre 3
    applyStimulus(5'h1F, 5'h17);
    expectDone(5'h00, 5'h00, 8'd3);
    expectDone(5'h08, 5'h08, 8'd3);
    expectDone(5'h18, 5'h08, 8'd3);
    expectDone(5'h19, 5'h08, 8'd3);
    expectDone(5'h1B, 5'h08, 8'd3);
    expectDone(5'h1F, 5'h08, 8'd3);
    for (int i = 0; i < MAX_RETRY; i++) expectPulse(3, RST_CYCLES);
    expectPulse(4, RST_CYCLES);
    expectPulse(0, RST_CYCLES);
    expectPulse(1, RST_CYCLES);
    expectPulse(2, RST_CYCLES);
    pulseTtc();
    waitDone(5'h1F, 1500, "t3 done");
    checkOutput("t3 fail", 32'(cfeb_sync_fail), 32'h08);
    applyStimulus(5'h1F, 5'h1F);
    repeat (5) @(negedge clock);

    // Bad K-char after 40 good ones restarts the run
    expectDone(5'h1E, 5'h00, 8'd4);
    expectDone(5'h1F, 5'h00, 8'd4);
    expectPulse(0, RST_CYCLES);
    applyStimulus(5'h01, 5'h1F);
    pulseTtc();
    repeat (50) @(negedge clock);
    kchar[0] = 8'h1C;
    @(negedge clock);
    kchar[0] = 8'hBC;
    lat = 0;
    while (!cfeb_sync_done[0] && lat < 200) begin
      @(negedge clock);
      lat++;
    end
    checkOutput("t4 clocks after error", 32'(lat), 32'(GOOD_CNT + 1));
    repeat (5) @(negedge clock);

    // Abort during fibre 1 reset pulse; restart from fibre 1
    applyStimulus(5'h1F, 5'h1F);
    expectDone(5'h00, 5'h00, 8'd5);
    expectPulse(1, 3);
    expectPulse(1, RST_CYCLES);
    expectPulse(2, RST_CYCLES);
    expectPulse(3, RST_CYCLES);
    expectPulse(4, RST_CYCLES);
    expectPulse(0, RST_CYCLES);
    expectDone(5'h02, 5'h00, 8'd6);
    expectDone(5'h06, 5'h00, 8'd6);
    expectDone(5'h0E, 5'h00, 8'd6);
    expectDone(5'h1E, 5'h00, 8'd6);
    expectDone(5'h1F, 5'h00, 8'd6);
    pulseTtc();
    repeat (3) @(negedge clock);
    pulseTtc();
    checkOutput("t5 count", 32'(resync_count), 32'd6);
    checkOutput("t5 rx_reset dropped", 32'(cfeb_rx_reset), 32'h0);
    waitDone(5'h1F, 600, "t5 done");
    repeat (5) @(negedge clock);

    // Lost-sync edge ignored without auto enable, honoured with it
    auto_resync_en = 1'b0;
    cfebs_lostsync = 1'b1;
    repeat (10) @(negedge clock);
    checkOutput("t6 no start count", 32'(resync_count), 32'd6);
    checkOutput("t6 no start busy", 32'(resync_busy), 32'h0);
    checkOutput("t6 no start done", 32'(cfeb_sync_done), 32'h1F);
    cfebs_lostsync = 1'b0;
    repeat (2) @(negedge clock);
    auto_resync_en = 1'b1;
    repeat (2) @(negedge clock);
    expectDone(5'h00, 5'h00, 8'd7);
    expectDone(5'h02, 5'h00, 8'd7);
    expectDone(5'h06, 5'h00, 8'd7);
    expectDone(5'h0E, 5'h00, 8'd7);
    expectDone(5'h1E, 5'h00, 8'd7);
    expectDone(5'h1F, 5'h00, 8'd7);
    expectPulse(1, RST_CYCLES);
    expectPulse(2, RST_CYCLES);
    expectPulse(3, RST_CYCLES);
    expectPulse(4, RST_CYCLES);
    expectPulse(0, RST_CYCLES);
    cfebs_lostsync = 1'b1;
    @(negedge clock);
    cfebs_lostsync = 1'b0;
    waitDone(5'h1F, 600, "t6 done");
    repeat (5) @(negedge clock);

    // Fibre 2 disabled while waiting for lock: done without fail
    expectDone(5'h1B, 5'h00, 8'd8);
    expectDone(5'h1F, 5'h00, 8'd8);
    expectPulse(2, RST_CYCLES);
    applyStimulus(5'h04, 5'h1B);
    pulseTtc();
    repeat (30) @(negedge clock);
    applyStimulus(5'h00, 5'h1B);
    waitDone(5'h1F, 20, "t7 done");
    checkOutput("t7 fail", 32'(cfeb_sync_fail), 32'h0);
    checkOutput("t7 busy idle", 32'(resync_busy), 32'h0);
    applyStimulus(5'h1F, 5'h1F);
    repeat (5) @(negedge clock);

    checkOutput("done queue drained", 32'(doneQ.size()), 32'd0);
    checkOutput("pulse queue drained", 32'(pulseQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
